// File: rtl/core_pkg.sv
// Shared types and constants for the core memory subsystem.
package core_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned BE_W         = XLEN / 8;
    // Wide enough for the largest supported starvation limit (15).
    localparam int unsigned STARVE_CNT_W = 4;

    // Owner of the read response expected in the next cycle.
    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_IF   = 2'd1,
        RSP_DLD  = 2'd2,
        RSP_DST  = 2'd3
    } resp_state_e;

endpackage

// File: rtl/arb_prio_starve.sv
// Two-requester priority select: data wins by default, fetch is forced through
// once data has been granted STARVE_MAX times in a row while fetch waited.
module arb_prio_starve
    import core_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic if_req_i,
    input  logic dm_req_i,
    output logic if_gnt_o,
    output logic dm_gnt_o
);

    localparam logic [STARVE_CNT_W-1:0] StarveLimit = STARVE_CNT_W'(STARVE_MAX);

    logic [STARVE_CNT_W-1:0] starve_cnt_d, starve_cnt_q;
    logic                    force_if;

    // Grant select; grants are held off while reset is asserted.
    always_comb begin
        force_if = if_req_i && (starve_cnt_q == StarveLimit);
        if_gnt_o = rst_ni && if_req_i && (!dm_req_i || force_if);
        dm_gnt_o = rst_ni && dm_req_i && !force_if;
    end

    // Saturating count of data grants taken while fetch was waiting.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!if_req_i || if_gnt_o) begin
            starve_cnt_d = '0;
        end else if (dm_gnt_o && (starve_cnt_q != StarveLimit)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// one access per cycle, routing the 1-cycle read response back to its owner.
module mem_arbiter
    import core_pkg::*;
#(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = XLEN,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            if_req_i,
    input  logic [AW-1:0]   if_addr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [DW-1:0]   if_rdata_o,
    input  logic            dm_req_i,
    input  logic            dm_we_i,
    input  logic [DW/8-1:0] dm_be_i,
    input  logic [AW-1:0]   dm_addr_i,
    input  logic [DW-1:0]   dm_wdata_i,
    output logic            dm_gnt_o,
    output logic            dm_rvalid_o,
    output logic [DW-1:0]   dm_rdata_o,
    output logic            mem_en_o,
    output logic            mem_we_o,
    output logic [DW/8-1:0] mem_be_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW-1:0]   mem_wdata_o,
    input  logic [DW-1:0]   mem_rdata_i
);

    resp_state_e resp_state_d, resp_state_q;

    arb_prio_starve #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .if_req_i (if_req_i),
        .dm_req_i (dm_req_i),
        .if_gnt_o (if_gnt_o),
        .dm_gnt_o (dm_gnt_o)
    );

    // Memory port mux; grants are already gated by reset so mem_en_o is too.
    always_comb begin
        mem_en_o    = if_gnt_o | dm_gnt_o;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (if_gnt_o) begin
            mem_be_o   = '1;
            mem_addr_o = if_addr_i;
        end else if (dm_gnt_o) begin
            mem_we_o    = dm_we_i;
            mem_be_o    = dm_be_i;
            mem_addr_o  = dm_addr_i;
            mem_wdata_o = dm_wdata_i;
        end
    end

    // Next response owner, derived fresh from this cycle's grant.
    always_comb begin
        resp_state_d = RSP_NONE;
        if (if_gnt_o) begin
            resp_state_d = RSP_IF;
        end else if (dm_gnt_o) begin
            resp_state_d = dm_we_i ? RSP_DST : RSP_DLD;
        end
    end

    // Response state register; reset drops any in-flight response.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            resp_state_q <= RSP_NONE;
        end else begin
            resp_state_q <= resp_state_d;
        end
    end

    // Response routing; non-owners see zero data.
    always_comb begin
        if_rvalid_o = 1'b0;
        if_rdata_o  = '0;
        dm_rvalid_o = 1'b0;
        dm_rdata_o  = '0;
        unique case (resp_state_q)
            RSP_IF: begin
                if_rvalid_o = 1'b1;
                if_rdata_o  = mem_rdata_i;
            end
            RSP_DLD: begin
                dm_rvalid_o = 1'b1;
                dm_rdata_o  = mem_rdata_i;
            end
            RSP_DST: begin
                dm_rvalid_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-enabled memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o, if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        dm_req_i, dm_we_i;
    logic [3:0]  dm_be_i;
    logic [31:0] dm_addr_i, dm_wdata_i;
    logic        dm_gnt_o, dm_rvalid_o;
    logic [31:0] dm_rdata_o;
    logic        mem_en_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [31:0] mem_rdata_i = 32'h0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .AW         (32),
        .DW         (32),
        .STARVE_MAX (4)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_gnt_o    (if_gnt_o),
        .if_rvalid_o (if_rvalid_o),
        .if_rdata_o  (if_rdata_o),
        .dm_req_i    (dm_req_i),
        .dm_we_i     (dm_we_i),
        .dm_be_i     (dm_be_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_gnt_o    (dm_gnt_o),
        .dm_rvalid_o (dm_rvalid_o),
        .dm_rdata_o  (dm_rdata_o),
        .mem_en_o    (mem_en_o),
        .mem_we_o    (mem_we_o),
        .mem_be_o    (mem_be_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
    );

    // Single-port memory: byte writes, registered reads.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_en_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) mem[mem_addr_o[9:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end else begin
                mem_rdata_i <= mem[mem_addr_o[9:2]];
            end
        end
    end

    // Protocol monitor: a request may not drop before it is granted.
    logic if_pend = 1'b0;
    logic dm_pend = 1'b0;
    always @(negedge clk) begin
        assert (!(if_pend && !if_req_i)) else begin
            bad++;
            $display("FAIL protocol: if_req_i dropped without grant");
        end
        assert (!(dm_pend && !dm_req_i)) else begin
            bad++;
            $display("FAIL protocol: dm_req_i dropped without grant");
        end
        assert (!(if_gnt_o && dm_gnt_o)) else begin
            bad++;
            $display("FAIL onehot: both grants high");
        end
        if_pend = rst_ni && if_req_i && !if_gnt_o;
        dm_pend = rst_ni && dm_req_i && !dm_gnt_o;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [3:0]  dm_be;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic        e_if_gnt;
        logic        e_dm_gnt;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_if_rv;
        logic [31:0] e_if_rd;
        logic        e_dm_rv;
        logic [31:0] e_dm_rd;
    } vec_t;

    vec_t tbl [11];

    initial begin
        // Stimulus rows: one per cycle; rvalid columns describe the previous row's access.
        tbl[0]  = '{0, 32'h0,   1, 1, 4'h3, 32'h200, 32'hDEADBEEF,
                    0, 1, 1, 4'h3, 32'h200, 32'hDEADBEEF, 0, 32'h0, 0, 32'h0};
        tbl[1]  = '{0, 32'h0,   1, 0, 4'hF, 32'h200, 32'h0,
                    0, 1, 0, 4'hF, 32'h200, 32'h0,        0, 32'h0, 1, 32'h0};
        tbl[2]  = '{1, 32'h100, 0, 0, 4'h0, 32'h0,   32'h0,
                    1, 0, 0, 4'hF, 32'h100, 32'h0,        0, 32'h0, 1, 32'h0000BEEF};
        tbl[3]  = '{0, 32'h0,   1, 0, 4'hF, 32'h300, 32'h0,
                    0, 1, 0, 4'hF, 32'h300, 32'h0,        1, 32'h00500093, 0, 32'h0};
        tbl[4]  = '{1, 32'h104, 0, 0, 4'h0, 32'h0,   32'h0,
                    1, 0, 0, 4'hF, 32'h104, 32'h0,        0, 32'h0, 1, 32'h22222222};
        tbl[5]  = '{0, 32'h0,   1, 0, 4'hF, 32'h200, 32'h0,
                    0, 1, 0, 4'hF, 32'h200, 32'h0,        1, 32'h11111111, 0, 32'h0};
        tbl[6]  = '{0, 32'h0,   0, 0, 4'h0, 32'h0,   32'h0,
                    0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0, 1, 32'h0000BEEF};
        tbl[7]  = '{0, 32'h0,   0, 0, 4'h0, 32'h0,   32'h0,
                    0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0, 0, 32'h0};
        tbl[8]  = '{0, 32'h0,   1, 1, 4'hC, 32'h204, 32'hCAFEF00D,
                    0, 1, 1, 4'hC, 32'h204, 32'hCAFEF00D, 0, 32'h0, 0, 32'h0};
        tbl[9]  = '{0, 32'h0,   1, 0, 4'hF, 32'h204, 32'h0,
                    0, 1, 0, 4'hF, 32'h204, 32'h0,        0, 32'h0, 1, 32'h0};
        tbl[10] = '{0, 32'h0,   0, 0, 4'h0, 32'h0,   32'h0,
                    0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0, 1, 32'hCAFE0000};

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h40] = 32'h00500093;  // 0x100
        mem[8'h41] = 32'h11111111;  // 0x104
        mem[8'hC0] = 32'h22222222;  // 0x300

        // Reset held with both requests pending.
        rst_ni     = 1'b0;
        if_req_i   = 1'b1;
        if_addr_i  = 32'h100;
        dm_req_i   = 1'b1;
        dm_we_i    = 1'b0;
        dm_be_i    = 4'hF;
        dm_addr_i  = 32'h300;
        dm_wdata_i = 32'h0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_if_gnt", if_gnt_o, 0);
            chk("rst_dm_gnt", dm_gnt_o, 0);
            chk("rst_mem_en", mem_en_o, 0);
            chk("rst_if_rvalid", if_rvalid_o, 0);
            chk("rst_dm_rvalid", dm_rvalid_o, 0);
        end

        // Release: data wins, then the stalled fetch goes.
        next_cycle();
        rst_ni = 1'b1;
        @(negedge clk);
        chk("rel_dm_gnt", dm_gnt_o, 1);
        chk("rel_if_gnt", if_gnt_o, 0);
        chk("rel_mem_addr", mem_addr_o, 32'h300);
        next_cycle();
        dm_req_i = 1'b0;
        @(negedge clk);
        chk("rel_if_gnt2", if_gnt_o, 1);
        chk("rel_mem_addr2", mem_addr_o, 32'h100);
        chk("rel_mem_we", mem_we_o, 0);
        chk("rel_dm_rvalid", dm_rvalid_o, 1);
        chk("rel_dm_rdata", dm_rdata_o, 32'h22222222);
        next_cycle();
        if_req_i = 1'b0;
        @(negedge clk);
        chk("fetch_rvalid", if_rvalid_o, 1);
        chk("fetch_rdata", if_rdata_o, 32'h00500093);
        chk("fetch_idle_en", mem_en_o, 0);

        // Contention: expect D,D,D,D,F,D,D,D,D,F.
        next_cycle();
        if_req_i  = 1'b1;
        if_addr_i = 32'h104;
        dm_req_i  = 1'b1;
        dm_addr_i = 32'h300;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("cont_if_gnt[%0d]", i), if_gnt_o, (i == 4 || i == 9));
            chk($sformatf("cont_dm_gnt[%0d]", i), dm_gnt_o, !(i == 4 || i == 9));
            chk($sformatf("cont_if_rv[%0d]", i), if_rvalid_o, (i == 5));
            chk($sformatf("cont_dm_rv[%0d]", i), dm_rvalid_o, (i != 0 && i != 5));
            next_cycle();
        end
        if_req_i = 1'b0;
        @(negedge clk);
        chk("cont_tail_dm_gnt", dm_gnt_o, 1);
        chk("cont_tail_if_rv", if_rvalid_o, 1);
        chk("cont_tail_if_rd", if_rdata_o, 32'h11111111);
        next_cycle();
        dm_req_i = 1'b0;
        @(negedge clk);
        chk("cont_tail_dm_rv", dm_rvalid_o, 1);
        chk("cont_tail_dm_rd", dm_rdata_o, 32'h22222222);

        // Table: store/load, back-to-back alternation, response routing.
        for (int r = 0; r < 11; r++) begin
            next_cycle();
            if_req_i   = tbl[r].if_req;
            if_addr_i  = tbl[r].if_addr;
            dm_req_i   = tbl[r].dm_req;
            dm_we_i    = tbl[r].dm_we;
            dm_be_i    = tbl[r].dm_be;
            dm_addr_i  = tbl[r].dm_addr;
            dm_wdata_i = tbl[r].dm_wdata;
            @(negedge clk);
            chk($sformatf("v%0d_if_gnt", r), if_gnt_o, tbl[r].e_if_gnt);
            chk($sformatf("v%0d_dm_gnt", r), dm_gnt_o, tbl[r].e_dm_gnt);
            chk($sformatf("v%0d_mem_en", r), mem_en_o, tbl[r].e_if_gnt | tbl[r].e_dm_gnt);
            chk($sformatf("v%0d_mem_we", r), mem_we_o, tbl[r].e_we);
            chk($sformatf("v%0d_mem_be", r), mem_be_o, tbl[r].e_be);
            chk($sformatf("v%0d_mem_addr", r), mem_addr_o, tbl[r].e_addr);
            chk($sformatf("v%0d_mem_wdata", r), mem_wdata_o, tbl[r].e_wdata);
            chk($sformatf("v%0d_if_rv", r), if_rvalid_o, tbl[r].e_if_rv);
            chk($sformatf("v%0d_if_rd", r), if_rdata_o, tbl[r].e_if_rd);
            chk($sformatf("v%0d_dm_rv", r), dm_rvalid_o, tbl[r].e_dm_rv);
            chk($sformatf("v%0d_dm_rd", r), dm_rdata_o, tbl[r].e_dm_rd);
        end

        // Reset while a load response is in flight.
        next_cycle();
        dm_req_i  = 1'b1;
        dm_we_i   = 1'b0;
        dm_be_i   = 4'hF;
        dm_addr_i = 32'h300;
        @(negedge clk);
        chk("mid_dm_gnt", dm_gnt_o, 1);
        rst_ni = 1'b0;
        next_cycle();
        dm_req_i = 1'b0;
        @(negedge clk);
        chk("mid_dm_rvalid", dm_rvalid_o, 0);
        chk("mid_dm_rdata", dm_rdata_o, 32'h0);
        chk("mid_if_rvalid", if_rvalid_o, 0);
        chk("mid_mem_en", mem_en_o, 0);
        next_cycle();
        rst_ni = 1'b1;
        @(negedge clk);
        chk("post_dm_rvalid", dm_rvalid_o, 0);
        chk("post_mem_en", mem_en_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the fetch stage (instruction reads) and the execute/writeback stage (loads and stores).
- Grants at most one access per cycle and routes the 1-cycle-latency read response back to the owner.
- Prevents fetch starvation with a bounded data-priority counter.
- Replaces the split ROM/RAM porting and lets the core sequencer stall on grant instead of assuming a fixed fetch slot.

Parameters:
- AW, 32, address width in bits (byte address).
- DW, 32, data width in bits.
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits before fetch is forced; range 1..15.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  synchronous active-low reset.
- if_req_i  in  1  fetch request; held with if_addr_i stable until if_gnt_o.
- if_addr_i  in  AW  fetch byte address.
- if_gnt_o  out  1  fetch request accepted this cycle.
- if_rvalid_o  out  1  fetch read data valid (one cycle after grant).
- if_rdata_o  out  DW  fetch read data.
- dm_req_i  in  1  data request; held with all dm_* inputs stable until dm_gnt_o.
- dm_we_i  in  1  1 = store, 0 = load.
- dm_be_i  in  DW/8  store byte enables.
- dm_addr_i  in  AW  data byte address.
- dm_wdata_i  in  DW  store data.
- dm_gnt_o  out  1  data request accepted this cycle.
- dm_rvalid_o  out  1  data response valid: load data or store ack.
- dm_rdata_o  out  DW  load data; 0 for store acks.
- mem_en_o  out  1  memory access strobe.
- mem_we_o  out  1  memory write.
- mem_be_o  out  DW/8  memory byte enables.
- mem_addr_o  out  AW  memory byte address.
- mem_wdata_o  out  DW  memory write data.
- mem_rdata_i  in  DW  memory read data, valid the cycle after mem_en_o with mem_we_o=0.

Behaviour:
- Reset (rst_ni=0 at a clock edge):
  - resp_state_q=RSP_NONE, starve_cnt_q=0.
  - All gnt/rvalid outputs 0; rdata outputs 0.
  - mem_en_o=0 while rst_ni=0 (gated combinationally).
  - A response pending at reset is discarded; no rvalid follows reset.
- Grant is combinational, same cycle as req. Exactly one of if_gnt_o and dm_gnt_o may be 1; neither if no req.
- Priority: dm wins by default. Exception: if_req_i=1 and starve_cnt_q==STARVE_MAX, then fetch wins.
- starve_cnt_q update:
  - +1 (saturating at STARVE_MAX) when dm granted while if_req_i=1.
  - Cleared to 0 when fetch is granted or if_req_i=0.
  - Held otherwise.
- Memory drive:
  - mem_en_o = if_gnt_o|dm_gnt_o.
  - On fetch grant: we=0, be=all ones, addr=if_addr_i, wdata=0.
  - On dm grant: we, be, addr and wdata are passed from dm_*.
  - Idle: all fields 0.
- Response state machine resp_state_q, updated every cycle from the current grant, so back-to-back grants are supported:
  - RSP_NONE: no response next cycle.
  - RSP_IF: if_rvalid_o=1, if_rdata_o=mem_rdata_i.
  - RSP_DLD: dm_rvalid_o=1, dm_rdata_o=mem_rdata_i.
  - RSP_DST: dm_rvalid_o=1, dm_rdata_o=0.
- Non-owner rdata outputs are driven 0; rvalid is a single-cycle pulse.
- Latency: grant to rvalid is exactly 1 cycle. Throughput is 1 access per cycle.
- Addresses pass through unchanged; alignment is the requester's responsibility.
- Simultaneous if_req_i and dm_req_i with starve_cnt_q<STARVE_MAX: dm granted, fetch stalls and holds its request.
- A request deasserting without a grant is a protocol violation; it must be flagged by the bench assertion, and the RTL ignores it.

Decomposition:
- Shared package core_pkg holds:
  - resp_state enum: RSP_NONE=2'd0, RSP_IF=2'd1, RSP_DLD=2'd2, RSP_DST=2'd3.
  - Constants for XLEN=32 and the byte-enable width.
- Natural sub-module: arb_prio_starve, holding the combinational priority select plus the saturating starve counter, reusable for a future CSR/debug port.
- Response routing stays in mem_arbiter.

Test Plan:
- Reset: hold rst_ni=0 with both reqs=1 for 3 cycles -> gnt, rvalid and mem_en_o all 0. Release -> dm granted first cycle.
- Fetch only: if_req_i=1, if_addr_i=0x100, mem returns 0x00500093 -> if_gnt_o in cycle 0, mem_addr_o=0x100 with we=0, if_rvalid_o=1 with if_rdata_o=0x00500093 in cycle 1.
- Store then load, same address: dm store 0x200, be=4'b0011, wdata=0xDEADBEEF -> mem_we_o=1, mem_be_o=0011, dm_rvalid_o=1 with rdata 0. Next load 0x200 -> dm_rdata_o=0x0000BEEF from the memory model.
- Contention, STARVE_MAX=4: both reqs held continuously -> grants D,D,D,D,F,D,D,D,D,F; starve_cnt reaches 4 and clears after each fetch grant.
- Back-to-back: alternating fetch and load grants in consecutive cycles -> rvalid pulses route correctly each cycle, with no cross-contamination of rdata.
- Reset mid-operation: load granted in cycle N, rst_ni=0 at the edge of cycle N+1 -> no dm_rvalid_o in cycle N+1; all outputs 0.
